// File: rtl/nibble_serial_adder.sv
// Multi-cycle WIDTH-bit adder: one 4-bit ripple slice of full_adder cells is
// reused once per nibble, LSB-first, with the inter-nibble carry held in a register.

module full_adder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));
endmodule

module nibble_serial_adder #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_Valid,
    output logic             in_Ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             c_In,
    output logic             out_Valid,
    input  logic             out_Ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_Out,
    output logic             ovf
);
    localparam int NIB = WIDTH / 4;
    localparam int IW  = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [IW-1:0] LAST = IW'(NIB - 1);

    generate
        if (WIDTH < 4 || (WIDTH % 4) != 0) begin : g_bad_width
            $error("nibble_serial_adder: WIDTH must be a multiple of 4 and at least 4");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t state, state_next;

    logic [WIDTH-1:0] a_reg, b_reg;
    logic             carry;
    logic [IW-1:0]    idx;
    logic [3:0]       a_nib, b_nib, nib_sum;
    logic [4:0]       chain;
    logic             last_nib;
    logic             accept;

    assign in_Ready  = (state == IDLE);
    assign out_Valid = (state == DONE);
    assign accept    = in_Valid && in_Ready;
    assign last_nib  = (idx == LAST);

    // The only path between nibbles is the carry register feeding chain[0].
    assign a_nib    = a_reg[4*idx +: 4];
    assign b_nib    = b_reg[4*idx +: 4];
    assign chain[0] = carry;

    generate
        for (genvar k = 0; k < 4; k++) begin : g_slice
            full_adder u_fa (
                .a (a_nib[k]),
                .b (b_nib[k]),
                .ci(chain[k]),
                .s (nib_sum[k]),
                .co(chain[k+1])
            );
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept)    state_next = RUN;
            RUN:     if (last_nib)  state_next = DONE;
            DONE:    if (out_Ready) state_next = IDLE;
            default:                state_next = IDLE;
        endcase
    end

    // Operand capture and the per-nibble accumulate; result regs hold outside RUN.
    always_ff @(posedge clk) begin
        if (reset) begin
            a_reg <= '0;
            b_reg <= '0;
            carry <= 1'b0;
            idx   <= '0;
            sum   <= '0;
            c_Out <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        a_reg <= A;
                        b_reg <= B;
                        carry <= c_In;
                        idx   <= '0;
                    end
                end
                RUN: begin
                    sum[4*idx +: 4] <= nib_sum;
                    carry           <= chain[4];
                    idx             <= idx + 1'b1;
                    if (last_nib) begin
                        c_Out <= chain[4];
                        ovf   <= (a_reg[WIDTH-1] == b_reg[WIDTH-1]) &&
                                 (nib_sum[3] != a_reg[WIDTH-1]);
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_nibble_serial_adder.sv
// Directed self-checking bench for nibble_serial_adder (WIDTH=16).

module tb_nibble_serial_adder;
    logic        clk = 1'b0;
    logic        reset;
    logic        in_Valid;
    logic        in_Ready;
    logic [15:0] A, B;
    logic        c_In;
    logic        out_Valid;
    logic        out_Ready;
    logic [15:0] sum;
    logic        c_Out;
    logic        ovf;

    int checks = 0;
    int passes = 0;

    nibble_serial_adder #(.WIDTH(16)) dut (
        .clk      (clk),
        .reset    (reset),
        .in_Valid (in_Valid),
        .in_Ready (in_Ready),
        .A        (A),
        .B        (B),
        .c_In     (c_In),
        .out_Valid(out_Valid),
        .out_Ready(out_Ready),
        .sum      (sum),
        .c_Out    (c_Out),
        .ovf      (ovf)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present operands for one accept edge; returns in the first RUN cycle (T+1).
    task automatic start_op(input logic [15:0] a, input logic [15:0] b, input logic cin);
        A = a; B = b; c_In = cin; in_Valid = 1'b1;
        tick();
        in_Valid = 1'b0; A = 16'h0; B = 16'h0; c_In = 1'b0;
    endtask

    // Latency is counted in cycles from the accept cycle T; 0 means timeout.
    task automatic wait_done(output int lat);
        int c = 1;
        while (!out_Valid && c < 40) begin
            tick();
            c++;
        end
        lat = out_Valid ? c : 0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
        checks++;
        if (in_Ready !== 1'b1 || out_Valid !== 1'b0 || sum !== 16'h0 || c_Out !== 1'b0 || ovf !== 1'b0)
            $display("[TB] FAIL reset_state: got rdy=%b vld=%b sum=%h co=%b ovf=%b, want 1 0 0000 0 0",
                     in_Ready, out_Valid, sum, c_Out, ovf);
        else passes++;
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++;
            if (in_Ready !== 1'b1 || out_Valid !== 1'b0 || sum !== 16'h0 || c_Out !== 1'b0 || ovf !== 1'b0)
                $display("[TB] FAIL idle_hold[%0d]: got rdy=%b vld=%b sum=%h co=%b ovf=%b, want 1 0 0000 0 0",
                         i, in_Ready, out_Valid, sum, c_Out, ovf);
            else passes++;
        end
    endtask

    task automatic run_and_check(input string name, input logic [15:0] a, input logic [15:0] b,
                                 input logic cin, input logic [15:0] exp_sum,
                                 input logic exp_co, input logic exp_ovf);
        int lat;
        start_op(a, b, cin);
        wait_done(lat);
        checks++;
        if (lat !== 5) $display("[TB] FAIL %s_latency: got %0d, want 5", name, lat);
        else passes++;
        checks++;
        if (sum !== exp_sum || c_Out !== exp_co || ovf !== exp_ovf)
            $display("[TB] FAIL %s_result: got sum=%h co=%b ovf=%b, want sum=%h co=%b ovf=%b",
                     name, sum, c_Out, ovf, exp_sum, exp_co, exp_ovf);
        else passes++;
        out_Ready = 1'b1;
        tick();
        out_Ready = 1'b0;
        checks++;
        if (in_Ready !== 1'b1 || out_Valid !== 1'b0)
            $display("[TB] FAIL %s_release: got rdy=%b vld=%b, want 1 0", name, in_Ready, out_Valid);
        else passes++;
    endtask

    task automatic test_carry_ripple();
        run_and_check("ripple", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
    endtask

    task automatic test_overflow();
        run_and_check("ovf_pos", 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
        run_and_check("ovf_neg", 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1);
    endtask

    task automatic test_backpressure();
        int c = 1;
        start_op(16'h1234, 16'h4321, 1'b1);
        in_Valid = 1'b1; A = 16'hAAAA; B = 16'hAAAA;
        while (!out_Valid && c < 40) begin
            checks++;
            if (in_Ready !== 1'b0) $display("[TB] FAIL bp_run_ready: got %b, want 0", in_Ready);
            else passes++;
            tick();
            c++;
        end
        checks++;
        if (c !== 5) $display("[TB] FAIL bp_latency: got %0d, want 5", c);
        else passes++;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (out_Valid !== 1'b1 || in_Ready !== 1'b0 || sum !== 16'h5556 || c_Out !== 1'b0 || ovf !== 1'b0)
                $display("[TB] FAIL bp_hold[%0d]: got vld=%b rdy=%b sum=%h co=%b ovf=%b, want 1 0 5556 0 0",
                         i, out_Valid, in_Ready, sum, c_Out, ovf);
            else passes++;
            if (i < 3) tick();
        end
        in_Valid = 1'b0; A = 16'h0; B = 16'h0;
        out_Ready = 1'b1;
        tick();
        out_Ready = 1'b0;
        tick();
        checks++;
        if (in_Ready !== 1'b1 || out_Valid !== 1'b0 || sum !== 16'h5556)
            $display("[TB] FAIL bp_after: got rdy=%b vld=%b sum=%h, want 1 0 5556", in_Ready, out_Valid, sum);
        else passes++;
    endtask

    task automatic test_back_to_back();
        int acc_cyc[2];
        logic [15:0] res[2];
        int n_acc = 0;
        int n_res = 0;
        logic accepted_prev = 1'b0;
        A = 16'h0001; B = 16'h0002; c_In = 1'b0;
        in_Valid = 1'b1; out_Ready = 1'b1;
        for (int cyc = 0; cyc < 20; cyc++) begin
            if (accepted_prev) begin
                if (n_acc == 1) begin A = 16'h00FF; B = 16'h0001; end
                else begin in_Valid = 1'b0; A = 16'h0; B = 16'h0; end
            end
            accepted_prev = 1'b0;
            if (in_Valid && in_Ready && n_acc < 2) begin
                acc_cyc[n_acc] = cyc;
                n_acc++;
                accepted_prev = 1'b1;
            end
            if (out_Valid && n_res < 2) begin
                res[n_res] = sum;
                n_res++;
            end
            tick();
        end
        out_Ready = 1'b0;
        in_Valid = 1'b0;
        checks++;
        if (n_acc !== 2 || n_res !== 2)
            $display("[TB] FAIL b2b_counts: got acc=%0d res=%0d, want 2 2", n_acc, n_res);
        else begin
            passes++;
            checks++;
            if (acc_cyc[1] - acc_cyc[0] !== 6)
                $display("[TB] FAIL b2b_spacing: got %0d, want 6", acc_cyc[1] - acc_cyc[0]);
            else passes++;
            checks++;
            if (res[0] !== 16'h0003 || res[1] !== 16'h0100)
                $display("[TB] FAIL b2b_results: got %h %h, want 0003 0100", res[0], res[1]);
            else passes++;
        end
    endtask

    task automatic test_reset_mid_run();
        int seen = 0;
        start_op(16'hFFFF, 16'hFFFF, 1'b0);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if (in_Ready !== 1'b1 || out_Valid !== 1'b0 || sum !== 16'h0 || c_Out !== 1'b0 || ovf !== 1'b0)
            $display("[TB] FAIL midrst_state: got rdy=%b vld=%b sum=%h co=%b ovf=%b, want 1 0 0000 0 0",
                     in_Ready, out_Valid, sum, c_Out, ovf);
        else passes++;
        for (int i = 0; i < 8; i++) begin
            if (out_Valid) seen++;
            tick();
        end
        checks++;
        if (seen !== 0) $display("[TB] FAIL midrst_no_valid: got %0d valid cycles, want 0", seen);
        else passes++;
        run_and_check("midrst_next", 16'h0010, 16'h0020, 1'b0, 16'h0030, 1'b0, 1'b0);
    endtask

    initial begin
        reset = 1'b1; in_Valid = 1'b0; A = 16'h0; B = 16'h0; c_In = 1'b0; out_Ready = 1'b0;
        #1;
        test_reset();
        test_carry_ripple();
        test_overflow();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_run();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
